// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encoding, address constants
// and a small per-port flag selector used by the FSM, synchronizer and register block.
package router_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] INVALID_ADDR = 2'b11;

  // Binary 3-bit state encoding
  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  // Selects the flag of port idx; an out-of-range index reads as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] v, input logic [1:0] idx);
    port_bit = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (idx == 2'(k)) port_bit = v[k];
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: address decode, drain wait,
// header/payload/parity loading and FIFO-full pause. Outputs are Moore decodes.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       sft_rst0,
  input  logic       sft_rst1,
  input  logic       sft_rst2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       wrt_enb_reg,
  output logic       busy,
  output logic [1:0] port_sel
);

  logic [2:0]           state_q, state_d;
  logic [1:0]           port_sel_q, port_sel_d;
  logic [NUM_PORTS-1:0] empty_v, sft_v;
  logic                 addr_ok;

  assign empty_v = {empty_2, empty_1, empty_0};
  assign sft_v   = {sft_rst2, sft_rst1, sft_rst0};
  assign addr_ok = pkt_valid && (data_in != INVALID_ADDR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DECODE_ADDRESS:
        if (addr_ok)
          state_d = port_bit(empty_v, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (port_bit(empty_v, port_sel_q)) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase
    // A timeout on the selected port abandons the packet from any busy state
    if (state_q != DECODE_ADDRESS && port_bit(sft_v, port_sel_q))
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    port_sel_d = port_sel_q;
    if (state_q == DECODE_ADDRESS && addr_ok) port_sel_d = data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DECODE_ADDRESS;
      port_sel_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      port_sel_q <= port_sel_d;
    end
  end

  assign detect_add  = (state_q == DECODE_ADDRESS);
  assign lfd_state   = (state_q == LOAD_FIRST_DATA);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
  assign wrt_enb_reg = ld_state || laf_state || (state_q == LOAD_PARITY);
  assign busy        = !(detect_add || ld_state);
  assign port_sel    = port_sel_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks every transition with hand-computed
// output vectors {detect_add,lfd,ld,laf,full,rst_int,wrt_enb,busy}.
module tb_router_fsm;

  logic clk = 1'b0;
  logic rst;
  logic pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic empty_0, empty_1, empty_2, sft_rst0, sft_rst1, sft_rst2;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic rst_int_reg, wrt_enb_reg, busy;
  logic [1:0] port_sel;

  int pass_cnt = 0;
  int total    = 0;

  // Expected output vectors per state
  localparam logic [7:0] V_DA  = 8'b1000_0000;
  localparam logic [7:0] V_LFD = 8'b0100_0001;
  localparam logic [7:0] V_LD  = 8'b0010_0010;
  localparam logic [7:0] V_LAF = 8'b0001_0011;
  localparam logic [7:0] V_FFS = 8'b0000_1001;
  localparam logic [7:0] V_LP  = 8'b0000_0011;
  localparam logic [7:0] V_CPE = 8'b0000_0101;
  localparam logic [7:0] V_WTE = 8'b0000_0001;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .sft_rst0(sft_rst0), .sft_rst1(sft_rst1), .sft_rst2(sft_rst2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .wrt_enb_reg(wrt_enb_reg), .busy(busy), .port_sel(port_sel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, wrt_enb_reg, busy};
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_ps(input string tag, input logic [1:0] exp);
    total++;
    assert (port_sel === exp) pass_cnt++;
    else $error("FAIL %s: port_sel observed %0d expected %0d", tag, port_sel, exp);
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 0; data_in = 0; fifo_full = 0; parity_done = 0;
    low_pkt_valid = 0; empty_0 = 0; empty_1 = 0; empty_2 = 0;
    sft_rst0 = 0; sft_rst1 = 0; sft_rst2 = 0;
    #3;
    chk_out("reset_out", V_DA);
    chk_ps("reset_ps", 2'd0);
    #10 rst = 1'b1;

    // Clean packet to port 1
    pkt_valid = 1; data_in = 1; empty_1 = 1;
    step(); chk_out("p1_lfd", V_LFD); chk_ps("p1_ps", 2'd1);
    step(); chk_out("p1_ld0", V_LD);
    step(); chk_out("p1_ld1", V_LD);
    step(); chk_out("p1_ld2", V_LD);
    step(); chk_out("p1_ld3", V_LD);
    pkt_valid = 0;
    step(); chk_out("p1_lp", V_LP);
    step(); chk_out("p1_cpe", V_CPE);
    step(); chk_out("p1_da", V_DA);
    empty_1 = 0;

    // Asynchronous reset while in LOAD_DATA
    pkt_valid = 1; data_in = 2; empty_2 = 1;
    step(); chk_out("mr_lfd", V_LFD);
    step(); chk_out("mr_ld", V_LD); chk_ps("mr_ps2", 2'd2);
    #2 rst = 1'b0;
    #1 chk_out("mr_async", V_DA); chk_ps("mr_ps0", 2'd0);
    pkt_valid = 0; empty_2 = 0;
    step(); chk_out("mr_hold", V_DA);
    rst = 1'b1;

    // Busy target: wait for port 2 to drain
    pkt_valid = 1; data_in = 2; empty_2 = 0;
    step(); chk_out("wte_0", V_WTE); chk_ps("wte_ps", 2'd2);
    for (int i = 1; i < 7; i++) begin
      step(); chk_out($sformatf("wte_%0d", i), V_WTE);
    end
    empty_2 = 1;
    step(); chk_out("wte_lfd", V_LFD);
    pkt_valid = 0;
    step(); chk_out("wte_ld", V_LD);
    step(); chk_out("wte_lp", V_LP);
    step(); chk_out("wte_cpe", V_CPE);
    step(); chk_out("wte_da", V_DA);
    empty_2 = 0;

    // FIFO full during payload, resume to LOAD_DATA
    pkt_valid = 1; data_in = 0; empty_0 = 1;
    step(); chk_out("ff_lfd", V_LFD);
    step(); chk_out("ff_ld", V_LD);
    fifo_full = 1;
    step(); chk_out("ff_ffs0", V_FFS);
    step(); chk_out("ff_ffs1", V_FFS);
    step(); chk_out("ff_ffs2", V_FFS);
    fifo_full = 0;
    step(); chk_out("ff_laf", V_LAF);
    step(); chk_out("ff_ld2", V_LD);
    // low_pkt_valid path
    fifo_full = 1;
    step(); chk_out("lp_ffs", V_FFS);
    fifo_full = 0;
    step(); chk_out("lp_laf", V_LAF);
    low_pkt_valid = 1;
    step(); chk_out("lp_lp", V_LP);
    low_pkt_valid = 0; pkt_valid = 0; fifo_full = 1;
    step(); chk_out("lp_cpe", V_CPE);
    step(); chk_out("cpe_full", V_FFS);
    fifo_full = 0;
    step(); chk_out("pd_laf", V_LAF);
    parity_done = 1;
    step(); chk_out("pd_da", V_DA);
    parity_done = 0;

    // fifo_full wins over !pkt_valid in LOAD_DATA
    pkt_valid = 1;
    step(); chk_out("fw_lfd", V_LFD);
    step(); chk_out("fw_ld", V_LD);
    fifo_full = 1; pkt_valid = 0;
    step(); chk_out("fw_ffs", V_FFS);
    fifo_full = 0;
    step(); chk_out("fw_laf", V_LAF);
    step(); chk_out("fw_ld2", V_LD);
    step(); chk_out("fw_lp", V_LP);
    step(); chk_out("fw_cpe", V_CPE);
    step(); chk_out("fw_da", V_DA);
    empty_0 = 0;

    // Soft reset of the selected port
    pkt_valid = 1; data_in = 0;
    step(); chk_out("sr0_wte", V_WTE); chk_ps("sr0_ps", 2'd0);
    sft_rst0 = 1;
    step(); chk_out("sr0_da", V_DA);
    sft_rst0 = 0; pkt_valid = 0;
    step(); chk_out("sr0_idle", V_DA);
    // Soft reset of a non-selected port is ignored
    pkt_valid = 1; data_in = 1;
    step(); chk_out("sr1_wte", V_WTE); chk_ps("sr1_ps", 2'd1);
    sft_rst0 = 1;
    step(); chk_out("sr1_ignore", V_WTE);
    sft_rst0 = 0; sft_rst1 = 1;
    step(); chk_out("sr1_da", V_DA);
    sft_rst1 = 0;

    // Invalid address: stay, port_sel holds
    pkt_valid = 1; data_in = 3;
    step(); chk_out("inv_da0", V_DA); chk_ps("inv_ps0", 2'd1);
    step(); chk_out("inv_da1", V_DA); chk_ps("inv_ps1", 2'd1);
    pkt_valid = 0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
